uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 118 +++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver running on an OVS x baud oversample clock.
// Mid-bit sampling after a 2-flop synchronizer; a low stop bit parks the FSM in BREAK until the line idles.
module uart_rx #(
    parameter int OVS = 16
) (
    input  logic       clk_s,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       led_rx
);

    localparam int CW = (OVS > 1) ? $clog2(OVS) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    // cnt lags t by one inside START, so the mid-start compare uses OVS/2-1
    localparam logic [CW-1:0] HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVS - 1);

    logic [1:0]    sync;
    logic          rxs;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          stop_pend;
    logic          stop_bit;

    assign rxs  = sync[1];
    assign busy = (state != IDLE);

    always_ff @(posedge clk_s or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    always_ff @(posedge clk_s or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            stop_pend <= 1'b0;
            stop_bit  <= 1'b0;
            data_out  <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            led_rx    <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // stop level is captured first and acted on one cycle later
                    if (stop_pend) begin
                        stop_pend <= 1'b0;
                        cnt       <= '0;
                        if (stop_bit) begin
                            data_out <= shreg;
                            valid    <= 1'b1;
                            led_rx   <= ~led_rx;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else if (cnt == LAST) begin
                        stop_bit  <= rxs;
                        stop_pend <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a serial driver pushes expected bytes to a scoreboard,
// a negedge monitor pops them on valid and tracks pulse timing and busy duration.
module tb_uart_rx;

    localparam int OVS = 16;

    logic       clk_s;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       led_rx;

    uart_rx #(.OVS(OVS)) dut (
        .clk_s    (clk_s),
        .rst_n    (rst_n),
        .rx       (rx),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy),
        .frame_err(frame_err),
        .led_rx   (led_rx)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int n_fe     = 0;
    int n_busy   = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;
    int last_fe_cyc    = 0;
    logic       led_exp = 1'b0;
    logic [7:0] sb[$];

    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

    always @(posedge clk_s) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard consumer
    always @(negedge clk_s) begin
        logic [7:0] exp_b;
        if (busy) n_busy++;
        if (valid || frame_err) check("valid_fe_exclusive", 32'(valid & frame_err), 32'd0);
        if (valid) begin
            n_valid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_b = sb.pop_front();
                check("data_out", 32'(data_out), 32'(exp_b));
            end
            led_exp = ~led_exp;
            check("led_rx_toggle", 32'(led_rx), 32'(led_exp));
        end
        if (frame_err) begin
            n_fe++;
            last_fe_cyc = cyc;
        end
    end

    // all drivers start and end just after a rising edge
    task automatic align();
        @(posedge clk_s);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_s);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk_s);
    endtask

    task automatic tx_bit(input logic v);
        rx = v;
        repeat (OVS) @(posedge clk_s);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        if (stop) sb.push_back(b);
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(b[i]);
        tx_bit(stop);
    endtask

    task automatic do_reset();
        @(negedge clk_s);
        rst_n = 1'b0;
        #1;
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_led_rx", 32'(led_rx), 32'd0);
        led_exp = 1'b0;
        @(negedge clk_s);
        @(negedge clk_s);
        rst_n = 1'b1;
        idle(5);
    endtask

    initial begin
        int e, nv0, nf0, nb0;
        rx    = 1'b1;
        rst_n = 1'b1;
        idle(2);
        do_reset();

        // single frame 0xAA: valid 153 cycles after the synchronized start (3 sync cycles)
        align();
        e = cyc; nv0 = n_valid; nb0 = n_busy;
        send(8'hAA, 1'b1);
        idle(10);
        check("aa_count", 32'(n_valid - nv0), 32'd1);
        check("aa_latency", 32'(last_valid_cyc - e), 32'd156);
        check("aa_busy_cycles", 32'(n_busy - nb0), 32'd153);
        check("aa_led", 32'(led_rx), 32'd1);

        // back-to-back 0x11, 0xAA from a fresh reset
        do_reset();
        align();
        e = cyc; nv0 = n_valid;
        send(8'h11, 1'b1);
        send(8'hAA, 1'b1);
        idle(10);
        check("b2b_count", 32'(n_valid - nv0), 32'd2);
        check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd160);
        check("b2b_second_latency", 32'(last_valid_cyc - e), 32'd316);
        check("b2b_led", 32'(led_rx), 32'd0);

        // 3-cycle low glitch: false start, busy for 8 cycles
        align();
        nv0 = n_valid; nf0 = n_fe; nb0 = n_busy;
        rx = 1'b0;
        repeat (3) @(posedge clk_s);
        #1;
        rx = 1'b1;
        idle(30);
        check("glitch_busy_cycles", 32'(n_busy - nb0), 32'd8);
        check("glitch_no_valid", 32'(n_valid - nv0), 32'd0);
        check("glitch_no_fe", 32'(n_fe - nf0), 32'd0);
        check("glitch_data_hold", 32'(data_out), 32'hAA);

        // 0x55 with low stop, line held low 40 more cycles
        align();
        e = cyc; nv0 = n_valid; nf0 = n_fe; nb0 = n_busy;
        send(8'h55, 1'b0);
        idle(40);
        rx = 1'b1;
        idle(20);
        check("fe_count", 32'(n_fe - nf0), 32'd1);
        check("fe_latency", 32'(last_fe_cyc - e), 32'd156);
        check("fe_no_valid", 32'(n_valid - nv0), 32'd0);
        check("fe_data_hold", 32'(data_out), 32'hAA);
        check("fe_led_hold", 32'(led_rx), 32'd0);
        check("fe_busy_cycles", 32'(n_busy - nb0), 32'd200);

        // reset at t=70 of 0x3C; driver aborts the frame with the receiver
        idle(5);
        align();
        e = cyc; nv0 = n_valid; nf0 = n_fe;
        tx_bit(1'b0);
        tx_bit(1'b0);
        tx_bit(1'b0);
        tx_bit(1'b1);
        rx = 1'b1;
        wait_cyc(e + 73);
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        do_reset();
        idle(20);
        check("mid_no_valid", 32'(n_valid - nv0), 32'd0);
        check("mid_no_fe", 32'(n_fe - nf0), 32'd0);
        align();
        send(8'h3C, 1'b1);
        idle(10);
        check("mid_clean_count", 32'(n_valid - nv0), 32'd1);
        check("mid_clean_data", 32'(data_out), 32'h3C);
        check("mid_clean_led", 32'(led_rx), 32'd1);

        // loopback burst
        align();
        nv0 = n_valid; nf0 = n_fe;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'hAA, 1'b1);
        send(8'h11, 1'b1);
        idle(20);
        check("loop_count", 32'(n_valid - nv0), 32'd4);
        check("loop_no_fe", 32'(n_fe - nf0), 32'd0);
        check("loop_last_data", 32'(data_out), 32'h11);
        check("loop_led", 32'(led_rx), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
